cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Parametrised successor to the trivial always-on clock-enable divider.
- Generates the processor-wide clk_en with a programmable divide ratio, and adds run/halt/single-step control.
- Honours the decoded HALT instruction, an external halt request and a PC breakpoint, and counts retired instructions.
- Sits beside the processor top; its clk_en_po drives the clk_en_pi of the program counter, register file and data memory.

Parameters:
- DIV, 4: clk_en period in clk_pi cycles; legal range ≥1; DIV=1 gives an enable every cycle.
- PC_W, 16: program counter width.
- CNT_W, 32: retired-instruction counter width.
- START_RUN, 1: reset state; 1 = RUN, 0 = HALTED.

Ports:
- clk_pi  in  1  system clock
- reset_n_pi  in  1  asynchronous active-low reset
- run_pi  in  1  request RUN (level, sampled each cycle)
- step_pi  in  1  request one instruction
- halt_req_pi  in  1  external halt request
- halt_cmd_pi  in  1  decoder HALT output for the current instruction
- pc_pi  in  PC_W  current PC
- bp_en_pi  in  1  breakpoint enable
- bp_addr_pi  in  PC_W  breakpoint address
- clr_count_pi  in  1  synchronous clear of the retired counter
- clk_en_po  out  1  one-cycle CPU enable pulse
- halted_po  out  1  1 when state is HALTED
- state_po  out  2  00 HALTED, 01 RUN, 10 STEP
- retired_po  out  CNT_W  retired-instruction count

Behaviour:
- One clock domain. All state updates on posedge clk_pi. reset_n_pi=0 acts immediately (async) and releases synchronously.
- Reset values:
  - state = RUN if START_RUN, else HALTED.
  - div_cnt = 0, retired_po = 0, bp_skip = 0.
  - halted_po = !START_RUN; state_po matches the reset state.
  - clk_en_po = 0 while reset is asserted.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps, in RUN and STEP only. It is held at 0 in HALTED.
  - tick = (div_cnt == DIV-1).
  - On entering RUN or STEP, the first tick comes DIV cycles later: DIV-1 cycles after the transition edge.
- bp_hit = bp_en_pi && (pc_pi == bp_addr_pi) && !bp_skip.
- clk_en_po = tick && state != HALTED && !halt_req_pi && !bp_hit. This is combinational from registered state plus inputs. It never exceeds one cycle for DIV>1 and is continuous in RUN for DIV=1.
- Transitions, evaluated each cycle:
  - HALTED:
    - run_pi → RUN.
    - else step_pi → STEP.
    - run_pi has priority over step_pi.
    - Leaving HALTED sets bp_skip = 1.
  - RUN:
    - halt_req_pi → HALTED, with the enable suppressed that cycle.
    - else tick && bp_hit → HALTED with no enable, so the instruction at the breakpoint is not executed.
    - else clk_en_po && halt_cmd_pi → HALTED after that enable; the HALT instruction retires.
    - else stay in RUN.
  - STEP:
    - halt_req_pi → HALTED with no enable.
    - else tick && bp_hit → HALTED with no enable.
    - else clk_en_po → HALTED after exactly one enable.
- bp_skip clears on the first clk_en_po pulse after it is set. Resuming from a breakpoint therefore executes the breakpoint instruction once.
- run_pi or step_pi asserted in RUN or STEP: ignored.
- retired_po:
  - Increments by 1 on every clk_en_po = 1 cycle and wraps modulo 2^CNT_W.
  - clr_count_pi clears it to 0, with priority over the increment in the same cycle.
- halted_po and state_po are registered and reflect the state after the edge.
- Reset asserted mid-RUN or mid-STEP: outputs return to reset values at once, with no partial pulse.

Test Plan:
1. DIV=4, START_RUN=1, release reset at t0 → clk_en_po high on cycles 3, 7, 11 after release; retired_po = 3 after cycle 11.
2. DIV=4, RUN, halt_cmd_pi=1 held while clk_en_po pulses once:
   - state_po goes to 00 and halted_po to 1 on the next edge.
   - retired_po increments once.
   - No further pulses over 20 cycles.
3. HALTED, DIV=1, pulse step_pi for 1 cycle:
   - state_po = 10 for one cycle.
   - Exactly one clk_en_po pulse, then back to 00.
   - retired_po +1.
4. RUN, DIV=2, bp_en_pi=1, bp_addr_pi=16'h0008, pc_pi reaching 16'h0008:
   - HALTED with no enable at PC 8.
   - Then run_pi=1 → first pulse occurs at PC 8, and execution continues past it.
5. RUN, DIV=4, halt_req_pi asserted in the same cycle as tick → clk_en_po=0 and HALTED next edge; retired_po unchanged.
6. CNT_W=4, retired_po = 4'hF, then one pulse → 4'h0. Separately, clr_count_pi asserted together with a pulse → 0. Separately, reset_n_pi=0 mid-RUN → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU clock-enable divider with run/halt/single-step control
//
// Purpose:
//   Produces the processor-wide one-cycle clk_en pulse at a programmable
//   divide ratio and gates it with a RUN / HALTED / STEP state machine.
//   The machine honours the decoded HALT instruction, an external halt
//   request and a PC breakpoint. It also counts retired instructions, where
//   one enable pulse retires one instruction.
//
// Ports:
//   clk_pi        in   system clock
//   reset_n_pi    in   asynchronous active-low reset
//   run_pi        in   request RUN (level)
//   step_pi       in   request a single instruction
//   halt_req_pi   in   external halt request
//   halt_cmd_pi   in   decoder HALT for the current instruction
//   pc_pi         in   current program counter
//   bp_en_pi      in   breakpoint enable
//   bp_addr_pi    in   breakpoint address
//   clr_count_pi  in   synchronous clear of the retired counter
//   clk_en_po     out  one-cycle CPU enable pulse
//   halted_po     out  1 when state is HALTED
//   state_po      out  00 HALTED, 01 RUN, 10 STEP
//   retired_po    out  retired-instruction count

module cpu_run_ctrl #(
  parameter int DIV       = 4,
  parameter int PC_W      = 16,
  parameter int CNT_W     = 32,
  parameter bit START_RUN = 1'b1
) (
  input  logic             clk_pi,
  input  logic             reset_n_pi,
  input  logic             run_pi,
  input  logic             step_pi,
  input  logic             halt_req_pi,
  input  logic             halt_cmd_pi,
  input  logic [PC_W-1:0]  pc_pi,
  input  logic             bp_en_pi,
  input  logic [PC_W-1:0]  bp_addr_pi,
  input  logic             clr_count_pi,
  output logic             clk_en_po,
  output logic             halted_po,
  output logic [1:0]       state_po,
  output logic [CNT_W-1:0] retired_po
);

  localparam logic [1:0] ST_HALTED = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;

  localparam logic [1:0] RESET_STATE = START_RUN ? ST_RUN : ST_HALTED;

  // DIV=1 still needs a one-bit counter so the vector is never zero-width.
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             bp_skip;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic             tick;
  logic             bp_hit;
  logic             clk_en;

  assign tick   = (div_cnt == DIV_LAST);

  // bp_skip masks the breakpoint for the first instruction after a resume,
  // so execution can move past the address it stopped on.
  assign bp_hit = bp_en_pi && (pc_pi == bp_addr_pi) && !bp_skip;

  // Gating with reset_n_pi keeps a pulse from leaking out while reset is
  // held. Without it a DIV=1, START_RUN=1 instance would pulse during reset.
  assign clk_en = reset_n_pi && tick && (state != ST_HALTED) &&
                  !halt_req_pi && !bp_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HALTED: begin
        if (run_pi)       state_nxt = ST_RUN;
        else if (step_pi) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req_pi)                    state_nxt = ST_HALTED;
        else if (tick && bp_hit)            state_nxt = ST_HALTED;
        else if (clk_en && halt_cmd_pi)     state_nxt = ST_HALTED;
      end
      ST_STEP: begin
        if (halt_req_pi)                    state_nxt = ST_HALTED;
        else if (tick && bp_hit)            state_nxt = ST_HALTED;
        else if (clk_en)                    state_nxt = ST_HALTED;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state   <= RESET_STATE;
      halted  <= !START_RUN;
      div_cnt <= '0;
      bp_skip <= 1'b0;
      retired <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == ST_HALTED);

      // The counter stays at 0 through HALTED and on the edge that enters
      // it. Each new RUN/STEP therefore starts counting from 0, and its
      // first tick lands DIV-1 cycles after the transition edge.
      if ((state == ST_HALTED) || (state_nxt == ST_HALTED)) begin
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if ((state == ST_HALTED) && (state_nxt != ST_HALTED)) begin
        bp_skip <= 1'b1;
      end else if (clk_en) begin
        bp_skip <= 1'b0;
      end

      if (clr_count_pi) begin
        retired <= '0;
      end else if (clk_en) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign clk_en_po  = clk_en;
  assign halted_po  = halted;
  assign state_po   = state;
  assign retired_po = retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk_pi = 1'b0;
  logic        reset_n_pi;
  logic        run_pi, step_pi, halt_req_pi, halt_cmd_pi;
  logic [15:0] pc_pi;
  logic        bp_en_pi;
  logic [15:0] bp_addr_pi;
  logic        clr_count_pi;

  // a: DIV=4 starts in RUN, b: DIV=1 starts HALTED with a 4-bit counter,
  // c: DIV=2 starts in RUN (breakpoint scenario).
  logic        a_clk_en, a_halted;
  logic [1:0]  a_state;
  logic [31:0] a_retired;
  logic        b_clk_en, b_halted;
  logic [1:0]  b_state;
  logic [3:0]  b_retired;
  logic        c_clk_en, c_halted;
  logic [1:0]  c_state;
  logic [31:0] c_retired;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_pi = ~clk_pi;

  cpu_run_ctrl #(.DIV(4), .PC_W(16), .CNT_W(32), .START_RUN(1'b1)) u_a (
    .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .run_pi(run_pi), .step_pi(step_pi),
    .halt_req_pi(halt_req_pi), .halt_cmd_pi(halt_cmd_pi), .pc_pi(pc_pi),
    .bp_en_pi(bp_en_pi), .bp_addr_pi(bp_addr_pi), .clr_count_pi(clr_count_pi),
    .clk_en_po(a_clk_en), .halted_po(a_halted), .state_po(a_state), .retired_po(a_retired));

  cpu_run_ctrl #(.DIV(1), .PC_W(16), .CNT_W(4), .START_RUN(1'b0)) u_b (
    .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .run_pi(run_pi), .step_pi(step_pi),
    .halt_req_pi(halt_req_pi), .halt_cmd_pi(halt_cmd_pi), .pc_pi(pc_pi),
    .bp_en_pi(bp_en_pi), .bp_addr_pi(bp_addr_pi), .clr_count_pi(clr_count_pi),
    .clk_en_po(b_clk_en), .halted_po(b_halted), .state_po(b_state), .retired_po(b_retired));

  cpu_run_ctrl #(.DIV(2), .PC_W(16), .CNT_W(32), .START_RUN(1'b1)) u_c (
    .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .run_pi(run_pi), .step_pi(step_pi),
    .halt_req_pi(halt_req_pi), .halt_cmd_pi(halt_cmd_pi), .pc_pi(pc_pi),
    .bp_en_pi(bp_en_pi), .bp_addr_pi(bp_addr_pi), .clr_count_pi(clr_count_pi),
    .clk_en_po(c_clk_en), .halted_po(c_halted), .state_po(c_state), .retired_po(c_retired));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Leaves the bench 1 time unit after the edge at which reset released,
  // i.e. at the start of "cycle 0".
  task automatic do_reset();
    reset_n_pi = 1'b0; run_pi = 1'b0; step_pi = 1'b0; halt_req_pi = 1'b0;
    halt_cmd_pi = 1'b0; bp_en_pi = 1'b0; bp_addr_pi = 16'h0; clr_count_pi = 1'b0;
    pc_pi = 16'h0;
    repeat (2) @(posedge clk_pi);
    #1 reset_n_pi = 1'b1;
  endtask

  task automatic next_cyc();
    @(posedge clk_pi);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic        en;
    int          pulses;
    logic [15:0] first_pc;
    logic        first_seen;

    // Test 1: reset values, then DIV=4 pulses on cycles 3, 7, 11.
    do_reset();
    #1;
    chk("a_rst_state", a_state, 2'b01);
    chk("a_rst_halted", a_halted, 1'b0);
    chk("a_rst_retired", a_retired, 0);
    chk("b_rst_state", b_state, 2'b00);
    chk("b_rst_halted", b_halted, 1'b1);
    next_cyc();
    for (int i = 1; i < 12; i++) begin
      #1 chk($sformatf("t1_en_c%0d", i), a_clk_en, (i % 4 == 3));
      next_cyc();
    end
    chk("t1_retired", a_retired, 3);

    // Test 2: HALT instruction retires, then no more pulses.
    halt_cmd_pi = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      #1;
      if (a_clk_en) found = 1'b1;
      else next_cyc();
    end
    chk("t2_pulse_seen", found, 1'b1);
    next_cyc();
    chk("t2_state", a_state, 2'b00);
    chk("t2_halted", a_halted, 1'b1);
    chk("t2_retired", a_retired, 4);
    halt_cmd_pi = 1'b0;
    pulses = 0;
    repeat (20) begin
      #1 if (a_clk_en) pulses++;
      next_cyc();
    end
    chk("t2_no_pulses", pulses, 0);

    // Test 5: halt request on the tick cycle suppresses the enable.
    do_reset();
    repeat (3) next_cyc();
    halt_req_pi = 1'b1;
    #1 chk("t5_en_suppressed", a_clk_en, 1'b0);
    next_cyc();
    halt_req_pi = 1'b0;
    chk("t5_state", a_state, 2'b00);
    chk("t5_retired", a_retired, 0);

    // Reset asserted on a tick cycle mid-RUN.
    do_reset();
    repeat (7) next_cyc();
    #1 chk("rst_pre_en", a_clk_en, 1'b1);
    chk("rst_pre_retired", a_retired, 1);
    reset_n_pi = 1'b0;
    #1;
    chk("rst_a_en", a_clk_en, 1'b0);
    chk("rst_c_en", c_clk_en, 1'b0);
    chk("rst_a_retired", a_retired, 0);
    chk("rst_a_state", a_state, 2'b01);
    chk("rst_a_halted", a_halted, 1'b0);

    // Test 3: single step from HALTED with DIV=1.
    do_reset();
    #1 chk("t3_idle_en", b_clk_en, 1'b0);
    step_pi = 1'b1;
    next_cyc();
    step_pi = 1'b0;
    #1;
    chk("t3_state_step", b_state, 2'b10);
    chk("t3_step_en", b_clk_en, 1'b1);
    next_cyc();
    chk("t3_state_back", b_state, 2'b00);
    chk("t3_halted", b_halted, 1'b1);
    chk("t3_retired", b_retired, 1);
    pulses = 0;
    repeat (5) begin
      #1 if (b_clk_en) pulses++;
      next_cyc();
    end
    chk("t3_no_more", pulses, 0);

    // Test 6: counter wrap and clear-over-increment (CNT_W=4).
    run_pi = 1'b1;
    next_cyc();
    run_pi = 1'b0;
    chk("t6_state_run", b_state, 2'b01);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (b_retired == 4'hF) found = 1'b1;
      else next_cyc();
    end
    chk("t6_reach_f", found, 1'b1);
    #1 chk("t6_en_at_f", b_clk_en, 1'b1);
    next_cyc();
    chk("t6_wrap", b_retired, 0);
    next_cyc();
    chk("t6_after_wrap", b_retired, 1);
    clr_count_pi = 1'b1;
    #1 chk("t6_en_with_clr", b_clk_en, 1'b1);
    next_cyc();
    clr_count_pi = 1'b0;
    chk("t6_clr", b_retired, 0);
    next_cyc();
    chk("t6_resume", b_retired, 1);

    // Test 4: breakpoint at PC 8 with DIV=2, then resume past it.
    do_reset();
    bp_en_pi = 1'b1;
    bp_addr_pi = 16'h0008;
    found = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1 en = c_clk_en;
      next_cyc();
      if (en) begin
        pc_pi = pc_pi + 16'h1;
        pulses++;
      end
      if (c_state == 2'b00) found = 1'b1;
    end
    chk("t4_halted_seen", found, 1'b1);
    chk("t4_pc_at_bp", pc_pi, 16'h0008);
    chk("t4_pulses", pulses, 8);
    chk("t4_halted", c_halted, 1'b1);
    chk("t4_retired", c_retired, 8);
    pulses = 0;
    repeat (3) begin
      #1 if (c_clk_en) pulses++;
      next_cyc();
    end
    chk("t4_idle", pulses, 0);
    run_pi = 1'b1;
    next_cyc();
    run_pi = 1'b0;
    chk("t4_resume_state", c_state, 2'b01);
    pulses = 0;
    first_seen = 1'b0;
    first_pc = 16'hFFFF;
    repeat (8) begin
      #1 en = c_clk_en;
      if (en && !first_seen) begin
        first_seen = 1'b1;
        first_pc = pc_pi;
      end
      next_cyc();
      if (en) begin
        pc_pi = pc_pi + 16'h1;
        pulses++;
      end
    end
    chk("t4_first_pc", first_pc, 16'h0008);
    chk("t4_resume_pulses", pulses, 4);
    chk("t4_pc_after", pc_pi, 16'h000C);
    chk("t4_still_run", c_state, 2'b01);
    chk("t4_retired_after", c_retired, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
